bp_pattern_table: RTL and testbench

Parametrised branch predictor for the fetch stage of the five-stage RV32I pipeline. It replaces the single global 2-bit counter with a PC-indexed table of saturating counters and an optional global-history (gshare) index hash. It also keeps the immediate-based target generation and the execute-stage redirect override. Lookup is combinational in fetch; training arrives from execute one or more cycles later, carrying the index that was used at lookup.

---
 rtl/bp_pkg.sv | 39 +++
 rtl/bp_target_gen.sv | 39 +++
 rtl/bp_pattern_table.sv | 112 +++++++++++
 tb/tb_bp_pattern_table.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the fetch-stage branch predictor: opcodes, statistics
// width and the saturating-counter step used to train the pattern table.
package bp_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam int BP_STATS_W = 16;
    typedef logic [BP_STATS_W-1:0] bp_stats_t;

    localparam bp_stats_t BP_STATS_MAX = 16'hFFFF;

    // Moves a counter of 'width' bits one step toward taken or not-taken,
    // holding at 0 and at the all-ones ceiling of that width.
    function automatic logic [3:0] sat_step(
        input logic [3:0] ctr,
        input logic       taken,
        input logic [2:0] width
    );
        logic [3:0] max_v;
        logic [3:0] res_v;
        max_v = 4'hF >> (3'd4 - width);
        if (taken) begin
            if (ctr < max_v) begin
                res_v = ctr + 4'd1;
            end else begin
                res_v = ctr;
            end
        end else begin
            if (ctr != 4'd0) begin
                res_v = ctr - 4'd1;
            end else begin
                res_v = ctr;
            end
        end
        return res_v;
    endfunction

endpackage

// File: rtl/bp_target_gen.sv
// Immediate decode for B-type and JAL plus the PC-relative target adder.
// Shared with the decode-stage jump check, so it stays purely combinational.
module bp_target_gen
    import bp_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output logic        is_b,
    output logic        is_jal,
    output logic [31:0] target
);

    logic [31:0] imm_s;

    // Sign-extended immediate; anything that is not a branch or JAL adds zero.
    always_comb begin
        imm_s  = 32'd0;
        is_b   = 1'b0;
        is_jal = 1'b0;
        case (instr[6:0])
            OPC_BRANCH: begin
                is_b  = 1'b1;
                imm_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                         instr[11:8], 1'b0};
            end
            OPC_JAL: begin
                is_jal = 1'b1;
                imm_s  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                          instr[30:21], 1'b0};
            end
            default: begin
                imm_s = 32'd0;
            end
        endcase
    end

    assign target = pc + imm_s;

endmodule

// File: rtl/bp_pattern_table.sv
// PC-indexed table of saturating counters with optional gshare hashing,
// immediate target generation and execute-stage redirect override.
module bp_pattern_table
    import bp_pkg::*;
#(
    parameter  int ENTRIES = 64,
    parameter  int CTR_W   = 2,
    parameter  int GSHARE  = 0,
    parameter  int GHR_W   = 6,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      instr,
    input  logic [31:0]      PC,
    input  logic             redirect,
    input  logic [31:0]      Act_Target,
    input  logic             upd_valid,
    input  logic             upd_taken,
    input  logic [IDX_W-1:0] upd_index,
    input  logic             upd_pred,
    output logic             predict_taken,
    output logic [31:0]      Target_final,
    output logic [IDX_W-1:0] pred_index,
    output logic [15:0]      mispredict_cnt
);

    // Weakly taken: only the MSB set.
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1) << (CTR_W - 1);

    logic [CTR_W-1:0] ctr_r [ENTRIES];
    logic [GHR_W-1:0] ghr_r;
    logic [IDX_W-1:0] idx_s;
    bp_stats_t        mis_r;
    logic             is_b_s;
    logic             is_jal_s;
    logic [31:0]      tgt_s;

    bp_target_gen u_target_gen (
        .instr  (instr),
        .pc     (PC),
        .is_b   (is_b_s),
        .is_jal (is_jal_s),
        .target (tgt_s)
    );

    // Lookup index: word-aligned PC bits, optionally hashed with the history.
    always_comb begin
        idx_s = PC[IDX_W+1:2];
        if (GSHARE != 0) begin
            idx_s = PC[IDX_W+1:2] ^ IDX_W'(ghr_r);
        end else begin
            idx_s = PC[IDX_W+1:2];
        end
    end

    // Counter bank; lookups read the pre-update value when indices collide.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_r[i] <= CTR_INIT;
            end
        end else if (upd_valid) begin
            ctr_r[upd_index] <= CTR_W'(sat_step(4'(ctr_r[upd_index]), upd_taken, 3'(CTR_W)));
        end else begin
            ctr_r[upd_index] <= ctr_r[upd_index];
        end
    end

    // History only advances on resolved branches, never speculatively.
    generate
        if (GSHARE != 0) begin : g_ghr
            logic [GHR_W-1:0] ghr_next_s;

            if (GHR_W > 1) begin : g_shift
                assign ghr_next_s = {ghr_r[GHR_W-2:0], upd_taken};
            end else begin : g_single
                assign ghr_next_s = upd_taken;
            end

            // Global history register.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    ghr_r <= '0;
                end else if (upd_valid) begin
                    ghr_r <= ghr_next_s;
                end else begin
                    ghr_r <= ghr_r;
                end
            end
        end else begin : g_no_ghr
            assign ghr_r = '0;
        end
    endgenerate

    // Saturating mispredict statistics.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mis_r <= '0;
        end else if (upd_valid && (upd_taken != upd_pred) && (mis_r != BP_STATS_MAX)) begin
            mis_r <= mis_r + 16'd1;
        end else begin
            mis_r <= mis_r;
        end
    end

    assign predict_taken  = redirect | is_jal_s | (is_b_s & ctr_r[idx_s][CTR_W-1]);
    assign Target_final   = redirect ? Act_Target : tgt_s;
    assign pred_index     = idx_s;
    assign mispredict_cnt = mis_r;

endmodule

// File: tb/tb_bp_pattern_table.sv
// Randomised and directed check of bp_pattern_table against an array-based
// reference model; a plain instance and a small gshare instance share stimulus.
module tb_bp_pattern_table;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] instr;
    logic [31:0] PC;
    logic        redirect;
    logic [31:0] Act_Target;
    logic        upd_valid;
    logic        upd_taken;
    logic [5:0]  upd_index;
    logic        upd_pred;

    logic        p1, p2;
    logic [31:0] t1, t2;
    logic [5:0]  i1;
    logic [3:0]  i2;
    logic [15:0] m1, m2;

    int checks   = 0;
    int failures = 0;

    int mc1 [64];
    int mc2 [16];
    int mghr;
    int mmis;
    bit exp_isb;
    bit exp_isj;
    int exp_imm;

    always #5 clk = ~clk;

    bp_pattern_table u_dut (
        .clk(clk), .reset_n(reset_n), .instr(instr), .PC(PC),
        .redirect(redirect), .Act_Target(Act_Target),
        .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_index(upd_index),
        .upd_pred(upd_pred), .predict_taken(p1), .Target_final(t1),
        .pred_index(i1), .mispredict_cnt(m1)
    );

    bp_pattern_table #(.ENTRIES(16), .CTR_W(2), .GSHARE(1), .GHR_W(2)) u_dut_gs (
        .clk(clk), .reset_n(reset_n), .instr(instr), .PC(PC),
        .redirect(redirect), .Act_Target(Act_Target),
        .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_index(upd_index[3:0]),
        .upd_pred(upd_pred), .predict_taken(p2), .Target_final(t2),
        .pred_index(i2), .mispredict_cnt(m2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mc1[i] = 2;
        for (int i = 0; i < 16; i++) mc2[i] = 2;
        mghr = 0;
        mmis = 0;
    endtask

    function automatic int bump(input int c, input bit up);
        if (up) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    task automatic model_update();
        if (upd_valid) begin
            mc1[upd_index]      = bump(mc1[upd_index], upd_taken);
            mc2[upd_index[3:0]] = bump(mc2[upd_index[3:0]], upd_taken);
            mghr = ((mghr << 1) | int'(upd_taken)) & 3;
            if (upd_taken != upd_pred && mmis < 65535) mmis++;
        end
    endtask

    task automatic set_raw(input logic [31:0] word, input bit isb, input bit isj, input int imm);
        instr   = word;
        exp_isb = isb;
        exp_isj = isj;
        exp_imm = imm;
    endtask

    // Encodes an instruction from a chosen kind and immediate.
    task automatic set_instr(input int kind, input int imm);
        logic [12:0] b;
        logic [20:0] j;
        logic [6:0]  ops [5] = '{7'b0010011, 7'b0110011, 7'b0000011, 7'b0110111, 7'b1100111};
        logic [31:0] r;
        b = 13'(imm);
        j = 21'(imm);
        r = $urandom();
        if (kind == 0) begin
            set_raw({b[12], b[10:5], 5'd3, 5'd2, 3'b000, b[4:1], b[11], 7'b1100011}, 1'b1, 1'b0, imm);
        end else if (kind == 1) begin
            set_raw({j[20], j[10:1], j[11], j[19:12], 5'd1, 7'b1101111}, 1'b0, 1'b1, imm);
        end else begin
            set_raw({r[31:7], ops[$urandom_range(0, 4)]}, 1'b0, 1'b0, 0);
        end
    endtask

    task automatic check_outputs();
        int idx1, idx2;
        bit e1, e2;
        logic [31:0] etgt;
        #1;
        idx1 = int'((PC >> 2) & 32'd63);
        idx2 = int'((PC >> 2) & 32'd15) ^ mghr;
        e1 = redirect || exp_isj || (exp_isb && mc1[idx1] >= 2);
        e2 = redirect || exp_isj || (exp_isb && mc2[idx2] >= 2);
        etgt = redirect ? Act_Target : PC + 32'(exp_imm);
        check_eq("pred1", {31'd0, p1}, {31'd0, e1});
        check_eq("pred2", {31'd0, p2}, {31'd0, e2});
        check_eq("tgt1", t1, etgt);
        check_eq("tgt2", t2, etgt);
        check_eq("idx1", {26'd0, i1}, 32'(idx1));
        check_eq("idx2", {28'd0, i2}, 32'(idx2));
    endtask

    // One cycle: compare lookup, take the edge, compare statistics.
    task automatic step();
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
        check_eq("mis1", {16'd0, m1}, 32'(mmis));
        check_eq("mis2", {16'd0, m2}, 32'(mmis));
        @(negedge clk);
    endtask

    initial begin
        int r;
        reset_n = 1'b0; PC = 32'd0; redirect = 1'b0; Act_Target = 32'd0;
        upd_valid = 1'b0; upd_taken = 1'b0; upd_index = 6'd0; upd_pred = 1'b0;
        set_raw(32'h00000013, 1'b0, 1'b0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Reset value lookup
        PC = 32'h100;
        set_raw(32'h00000863, 1'b1, 1'b0, 16);
        #1;
        check_eq("t1_pred", {31'd0, p1}, 32'd1);
        check_eq("t1_tgt", t1, 32'h110);
        check_eq("t1_idx", {26'd0, i1}, 32'd0);
        check_eq("t1_mis", {16'd0, m1}, 32'd0);
        step();

        // Decrement to the floor
        upd_valid = 1'b1; upd_index = 6'd0; upd_taken = 1'b0; upd_pred = 1'b1;
        repeat (3) step();
        upd_valid = 1'b0;
        #1;
        check_eq("t2_pred", {31'd0, p1}, 32'd0);
        check_eq("t2_mis", {16'd0, m1}, 32'd3);
        step();

        // Increment to the ceiling
        upd_valid = 1'b1; upd_index = 6'd5; upd_taken = 1'b1; upd_pred = 1'b1;
        repeat (5) step();
        upd_valid = 1'b0;
        PC = 32'h14;
        #1;
        check_eq("t3_pred", {31'd0, p1}, 32'd1);
        check_eq("t3_idx", {26'd0, i1}, 32'd5);
        step();

        // JAL, non-branch, redirect
        PC = 32'h100;
        set_raw(32'h0080006F, 1'b0, 1'b1, 8);
        #1;
        check_eq("t4_jal_pred", {31'd0, p1}, 32'd1);
        check_eq("t4_jal_tgt", t1, 32'h108);
        step();
        set_raw(32'h00000013, 1'b0, 1'b0, 0);
        #1;
        check_eq("t4_nop_pred", {31'd0, p1}, 32'd0);
        step();
        redirect = 1'b1; Act_Target = 32'h2000;
        #1;
        check_eq("t4_rd_pred", {31'd0, p1}, 32'd1);
        check_eq("t4_rd_tgt", t1, 32'h2000);
        step();
        redirect = 1'b0;

        // Gshare history: taken then not-taken gives history 10
        upd_valid = 1'b1; upd_index = 6'd7; upd_taken = 1'b1; upd_pred = 1'b1;
        step();
        upd_taken = 1'b0; upd_pred = 1'b0;
        step();
        upd_valid = 1'b0;
        PC = 32'h0;
        set_raw(32'h00000863, 1'b1, 1'b0, 16);
        #1;
        check_eq("t5_gs_idx", {28'd0, i2}, 32'd2);
        step();

        // Same-cycle update and lookup sees the old counter
        PC = 32'h100;
        upd_valid = 1'b1; upd_index = 6'd0; upd_taken = 1'b1; upd_pred = 1'b0;
        #1;
        check_eq("t5_old_ctr", {31'd0, p1}, 32'd0);
        step();
        step();
        upd_valid = 1'b0;
        #1;
        check_eq("t5_new_ctr", {31'd0, p1}, 32'd1);
        step();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            PC = $urandom();
            r = int'($urandom_range(0, 2));
            if (r == 0) set_instr(0, (int'($urandom_range(0, 4095)) - 2048) * 2);
            else if (r == 1) set_instr(1, (int'($urandom_range(0, 1048575)) - 524288) * 2);
            else set_instr(2, 0);
            redirect   = ($urandom_range(0, 7) == 0);
            Act_Target = $urandom();
            upd_valid  = $urandom_range(0, 1);
            upd_taken  = $urandom_range(0, 1);
            upd_pred   = $urandom_range(0, 1);
            upd_index  = 6'($urandom_range(0, 63));
            step();
        end

        // Asynchronous reset pulse between edges
        upd_valid = 1'b0; redirect = 1'b0;
        PC = 32'h100;
        set_raw(32'h00000863, 1'b1, 1'b0, 16);
        reset_n = 1'b0;
        model_reset();
        #1;
        check_eq("t6_mis", {16'd0, m1}, 32'd0);
        check_eq("t6_mis_gs", {16'd0, m2}, 32'd0);
        check_eq("t6_pred", {31'd0, p1}, 32'd1);
        check_eq("t6_gs_idx", {28'd0, i2}, 32'd0);
        #2;
        reset_n = 1'b1;
        step();

        // Statistics saturate at 0xFFFF
        upd_valid = 1'b1; upd_index = 6'd1; upd_taken = 1'b1; upd_pred = 1'b0;
        for (int n = 0; n < 65540; n++) begin
            @(posedge clk);
            model_update();
        end
        #1;
        check_eq("t6_sat", {16'd0, m1}, 32'h0000FFFF);
        @(negedge clk);
        step();
        upd_valid = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
